// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point radix-2 DIT FFT blocks.
package fft8_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 9;

   // Stage-1 twiddle W0 = 1.0 + j0 in Q6.9
   localparam logic [DATA_W-1:0] W0_R = 16'h0200;
   localparam logic [DATA_W-1:0] W0_I = 16'h0000;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } cplx_t;

   typedef enum logic {
      FILL  = 1'b0,
      ISSUE = 1'b1
   } loader_state_e;

   // 3-bit bit reversal; also used by the output-reorder stage
   function automatic logic [2:0] bitrev3(input logic [2:0] n);
      return {n[0], n[1], n[2]};
   endfunction

endpackage

// File: rtl/fft8_bitrev_loader.sv
// FFT input stage: stores a natural-order frame of 8 samples at bit-reversed
// addresses, then issues the four stage-1 butterfly operand pairs.
module fft8_bitrev_loader #(
   parameter int DATA_W = fft8_pkg::DATA_W,
   parameter int FRAC_W = fft8_pkg::FRAC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_r,
   input  logic [DATA_W-1:0] in_i,
   output logic [DATA_W-1:0] x1_r,
   output logic [DATA_W-1:0] x1_i,
   output logic [DATA_W-1:0] x2_r,
   output logic [DATA_W-1:0] x2_i,
   output logic [DATA_W-1:0] w_r,
   output logic [DATA_W-1:0] w_i,
   output logic              start,
   output logic              frame_last
);

   import fft8_pkg::*;

   loader_state_e     state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [1:0]        k_q, k_d;
   logic              start_q, start_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] x1_r_q, x1_r_d, x1_i_q, x1_i_d;
   logic [DATA_W-1:0] x2_r_q, x2_r_d, x2_i_q, x2_i_d;
   logic [DATA_W-1:0] mem_re_q [8];
   logic [DATA_W-1:0] mem_im_q [8];
   logic              accept;
   logic              issue;
   logic [2:0]        rd_lo, rd_hi;

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state_q <= FILL;
      else     state_q <= state_d;
   end

   // Next-state: leave FILL on the 8th accepted sample, leave ISSUE after pair 3
   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         FILL:    if (accept && cnt_q == 3'd7) state_d = ISSUE;
         ISSUE:   if (k_q == 2'd3)             state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // State-decoded outputs and handshake
   always_comb begin
      in_ready = (state_q == FILL);
      issue    = (state_q == ISSUE);
      accept   = in_valid && in_ready;
   end

   // Sample counter, pair index and operand-register next values
   always_comb begin
      cnt_d   = cnt_q;
      k_d     = k_q;
      start_d = 1'b0;
      last_d  = 1'b0;
      x1_r_d  = x1_r_q;
      x1_i_d  = x1_i_q;
      x2_r_d  = x2_r_q;
      x2_i_d  = x2_i_q;
      rd_lo   = {k_q, 1'b0};
      rd_hi   = {k_q, 1'b1};
      // 3-bit counter wraps to 0 after sample 7
      if (accept) cnt_d = cnt_q + 3'd1;
      if (issue) begin
         // 2-bit index wraps to 0 after pair 3, ready for the next frame
         k_d     = k_q + 2'd1;
         start_d = 1'b1;
         last_d  = (k_q == 2'd3);
         x1_r_d  = mem_re_q[rd_lo];
         x1_i_d  = mem_im_q[rd_lo];
         x2_r_d  = mem_re_q[rd_hi];
         x2_i_d  = mem_im_q[rd_hi];
      end
   end

   // Counter, index and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         k_q     <= '0;
         start_q <= 1'b0;
         last_q  <= 1'b0;
         x1_r_q  <= '0;
         x1_i_q  <= '0;
         x2_r_q  <= '0;
         x2_i_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         start_q <= start_d;
         last_q  <= last_d;
         x1_r_q  <= x1_r_d;
         x1_i_q  <= x1_i_d;
         x2_r_q  <= x2_r_d;
         x2_i_q  <= x2_i_d;
      end
   end

   // Frame store: sample n lands at address bitrev3(n)
   always_ff @(posedge clk) begin
      // NOTE: no reset on the array; every entry is rewritten before it is read.
      if (accept) begin
         mem_re_q[bitrev3(cnt_q)] <= in_r;
         mem_im_q[bitrev3(cnt_q)] <= in_i;
      end
   end

   assign x1_r       = x1_r_q;
   assign x1_i       = x1_i_q;
   assign x2_r       = x2_r_q;
   assign x2_i       = x2_i_q;
   assign start      = start_q;
   assign frame_last = last_q;
   assign w_r        = DATA_W'(1) << FRAC_W;
   assign w_i        = '0;

endmodule

// File: tb/tb_fft8_bitrev_loader.sv
// Scoreboard bench for fft8_bitrev_loader.
module tb_fft8_bitrev_loader;
   import fft8_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_r = '0, in_i = '0;
   logic [15:0] x1_r, x1_i, x2_r, x2_i, w_r, w_i;
   logic        start, frame_last;

   fft8_bitrev_loader dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_r(in_r), .in_i(in_i),
      .x1_r(x1_r), .x1_i(x1_i), .x2_r(x2_r), .x2_i(x2_i),
      .w_r(w_r), .w_i(w_i), .start(start), .frame_last(frame_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      cplx_t a;
      cplx_t b;
      logic  last;
      int    exp_cyc;
      int    k;
   } pair_t;

   pair_t sb_q[$];
   int    first_starts[$];
   int    cyc = 0;
   int    win_lo = -1, win_hi = -1;
   bit    mon_en = 1'b0;
   int    n_checks = 0;
   int    n_passed = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Output monitor: compares every issued pair against the scoreboard head
   always @(negedge clk) begin
      if (mon_en) begin
         pair_t e;
         check("in_ready", in_ready, !(cyc >= win_lo && cyc <= win_hi));
         if (start) begin
            if (sb_q.size() == 0) begin
               check("unexpected_start", start, 1'b0);
            end else begin
               e = sb_q.pop_front();
               check("start_cyc", cyc, e.exp_cyc);
               check("x1_r", x1_r, e.a.re);
               check("x1_i", x1_i, e.a.im);
               check("x2_r", x2_r, e.b.re);
               check("x2_i", x2_i, e.b.im);
               check("frame_last", frame_last, e.last);
               check("w_r", w_r, 16'h0200);
               check("w_i", w_i, 16'h0000);
               if (e.k == 0) first_starts.push_back(cyc);
            end
         end else begin
            check("frame_last_idle", frame_last, 1'b0);
            if (sb_q.size() != 0 && sb_q[0].exp_cyc == cyc) check("missing_start", start, 1'b1);
         end
      end
   end

   function automatic cplx_t sample(input int kind, input int n);
      cplx_t s;
      case (kind)
         0:       begin s.re = 16'(n * 512);  s.im = 16'(-n);          end
         1:       begin s.re = 16'(-n * 512); s.im = 16'(n * 3);       end
         default: begin s.re = 16'(n * 97 + 5); s.im = 16'(1000 - n * 11); end
      endcase
      return s;
   endfunction

   // Drive one sample, waiting (bounded) for in_ready; returns acceptance cycle
   task automatic send(input cplx_t s, output int t_acc);
      bit done = 1'b0;
      t_acc    = -1;
      in_valid = 1'b1;
      in_r     = s.re;
      in_i     = s.im;
      for (int w = 0; w < 50 && !done; w++) begin
         @(negedge clk);
         if (in_ready) begin
            done  = 1'b1;
            t_acc = cyc;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check("send_timeout", {31'd0, done}, 32'd1);
   endtask

   // Send a full frame; expected pairs are pushed once sample 7 is accepted
   task automatic send_frame(input int kind, input bit gaps, input bit junk);
      cplx_t s[8];
      int    t;
      for (int n = 0; n < 8; n++) begin
         s[n] = sample(kind, n);
         if (gaps) begin
            int idle = $urandom_range(0, 2);
            in_valid = 1'b0;
            in_r     = 16'h7FFF;
            in_i     = 16'h7FFF;
            repeat (idle) begin
               @(posedge clk);
               #1;
            end
         end
         send(s[n], t);
      end
      win_lo = t + 1;
      win_hi = t + 4;
      sb_q.push_back('{a: s[0], b: s[4], last: 1'b0, exp_cyc: t + 2, k: 0});
      sb_q.push_back('{a: s[2], b: s[6], last: 1'b0, exp_cyc: t + 3, k: 1});
      sb_q.push_back('{a: s[1], b: s[5], last: 1'b0, exp_cyc: t + 4, k: 2});
      sb_q.push_back('{a: s[3], b: s[7], last: 1'b1, exp_cyc: t + 5, k: 3});
      if (junk) begin
         in_valid = 1'b1;
         in_r     = 16'h7FFF;
         in_i     = 16'h7FFF;
         repeat (4) begin
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int w = 0; w < 40 && sb_q.size() != 0; w++) @(posedge clk);
      check("drain_empty", sb_q.size(), 0);
      #1;
   endtask

   initial begin
      // Reset for two cycles, then check reset values in the first free cycle
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_start", start, 1'b0);
      check("rst_frame_last", frame_last, 1'b0);
      check("rst_x1_r", x1_r, 16'h0);
      check("rst_x1_i", x1_i, 16'h0);
      check("rst_x2_r", x2_r, 16'h0);
      check("rst_x2_i", x2_i, 16'h0);
      check("rst_w_r", w_r, 16'h0200);
      check("rst_w_i", w_i, 16'h0000);
      check("rst_in_ready", in_ready, 1'b1);
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Continuous frame
      send_frame(0, 1'b0, 1'b0);
      drain();

      // Same frame with random input gaps
      send_frame(0, 1'b1, 1'b0);
      drain();

      // in_valid held high with 0x7FFF during ISSUE, then a clean frame
      send_frame(2, 1'b0, 1'b1);
      drain();
      send_frame(0, 1'b0, 1'b0);
      drain();

      // Back-to-back frames: period between first starts is 12 cycles
      first_starts.delete();
      send_frame(0, 1'b0, 1'b0);
      send_frame(1, 1'b0, 1'b0);
      drain();
      if (first_starts.size() == 2) check("b2b_period", first_starts[1] - first_starts[0], 12);
      else check("b2b_first_starts", first_starts.size(), 2);

      // Reset during ISSUE (in T+3), then a fresh frame
      send_frame(0, 1'b0, 1'b0);   // returns at start of T+1
      @(posedge clk);
      #1;                          // T+2
      @(posedge clk);
      #1;                          // T+3
      rst = 1'b1;
      @(posedge clk);
      #1;                          // T+4
      rst = 1'b0;
      sb_q.delete();
      win_lo = -1;
      win_hi = -1;
      @(negedge clk);
      check("abort_start", start, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      send_frame(2, 1'b1, 1'b0);
      drain();
      send_frame(1, 1'b0, 1'b0);
      drain();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, got %0d/%0d", n_passed, n_checks);
      $fatal(1, "timeout");
   end

endmodule
